// File: rtl/instr_decode_rf.sv
// Decode and register-file stage of a single-cycle MIPS R-type datapath.
// Define ILLEGAL_CNT_EN to build the saturating illegal-instruction counter.
module instr_decode_rf #(
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [31:0]       Instruction_code,
  input  logic [31:0]       Write_data,
  output logic [31:0]       Read_data1,
  output logic [31:0]       Read_data2,
  output logic [4:0]        Shamt,
  output logic [3:0]        ALU_control,
  output logic              RegWrite,
  output logic              Illegal,
  output logic [CNT_W-1:0]  Illegal_count
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        supported;
  logic [3:0]  alu_ctl;

  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];
  logic        illegal_q;
  logic        illegal_d;

  assign opcode = Instruction_code[31:26];
  assign rs     = Instruction_code[25:21];
  assign rt     = Instruction_code[20:16];
  assign rd     = Instruction_code[15:11];
  assign Shamt  = Instruction_code[10:6];
  assign funct  = Instruction_code[5:0];

  always_comb begin
    supported = 1'b1;
    alu_ctl   = 4'hF;
    if (opcode != 6'd0) begin
      supported = 1'b0;
    end else begin
      case (funct)
        6'h20:   alu_ctl = 4'h2;
        6'h22:   alu_ctl = 4'h6;
        6'h24:   alu_ctl = 4'h0;
        6'h25:   alu_ctl = 4'h1;
        6'h27:   alu_ctl = 4'hC;
        6'h2A:   alu_ctl = 4'h7;
        6'h00:   alu_ctl = 4'h8;
        6'h02:   alu_ctl = 4'h9;
        default: supported = 1'b0;
      endcase
    end
  end

  assign ALU_control = alu_ctl;
  assign RegWrite    = supported;

  // No bypass: reads see the pre-edge contents, keeping the ALU loop registered.
  assign Read_data1 = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign Read_data2 = (rt == 5'd0) ? 32'd0 : regs_q[rt];

  always_comb begin
    regs_d = regs_q;
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_d[i] = 32'(i);
      end
    end else if (supported && (rd != 5'd0)) begin
      regs_d[rd] = Write_data;
    end
    regs_d[0] = 32'd0;
  end

  always_comb begin
    illegal_d = illegal_q;
    if (Reset) begin
      illegal_d = 1'b0;
    end else if (!supported) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    regs_q    <= regs_d;
    illegal_q <= illegal_d;
  end

  assign Illegal = illegal_q;

`ifdef ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Reset) begin
      cnt_d = '0;
    end else if (!supported && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign Illegal_count = cnt_q;
`else
  assign Illegal_count = '0;
`endif

endmodule

// File: tb/tb_instr_decode_rf.sv
// Directed self-checking bench for instr_decode_rf (both counter builds).
`timescale 1ns/1ps
module tb_instr_decode_rf;

  logic        clk;
  logic        Reset;
  logic [31:0] Instruction_code;
  logic [31:0] Write_data;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic [4:0]  Shamt;
  logic [3:0]  ALU_control;
  logic        RegWrite;
  logic        Illegal;
  logic [15:0] Illegal_count;

  logic        sat_reset;
  logic [31:0] sat_instr;
  logic [31:0] sat_wd;
  logic [31:0] sat_rd1;
  logic [31:0] sat_rd2;
  logic [4:0]  sat_shamt;
  logic [3:0]  sat_alu;
  logic        sat_rw;
  logic        sat_illegal;
  logic [1:0]  sat_count;

  int errors = 0;
  int checks = 0;

  instr_decode_rf dut (
    .clk(clk), .Reset(Reset), .Instruction_code(Instruction_code),
    .Write_data(Write_data), .Read_data1(Read_data1), .Read_data2(Read_data2),
    .Shamt(Shamt), .ALU_control(ALU_control), .RegWrite(RegWrite),
    .Illegal(Illegal), .Illegal_count(Illegal_count)
  );

  instr_decode_rf #(.NREGS(32), .CNT_W(2)) dut_sat (
    .clk(clk), .Reset(sat_reset), .Instruction_code(sat_instr),
    .Write_data(sat_wd), .Read_data1(sat_rd1), .Read_data2(sat_rd2),
    .Shamt(sat_shamt), .ALU_control(sat_alu), .RegWrite(sat_rw),
    .Illegal(sat_illegal), .Illegal_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ILLEGAL_CNT_EN
  localparam logic [15:0] ONE_ILLEGAL = 16'd1;
  localparam bit          CNT_ON      = 1'b1;
`else
  localparam logic [15:0] ONE_ILLEGAL = 16'd0;
  localparam bit          CNT_ON      = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] instr;
    Reset = 1'b1; sat_reset = 1'b1;
    Instruction_code = 32'h0000_0020; Write_data = 32'd0;
    sat_instr = 32'h0000_0020; sat_wd = 32'd0;
    tick();
    Reset = 1'b0; sat_reset = 1'b0;
    checks++;
    if (Illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got=%0b exp=0", Illegal); end
    checks++;
    if (Illegal_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", Illegal_count); end
    for (int i = 0; i < 4; i++) begin
      instr = (32'(i) << 21) | (32'(31 - i) << 16) | 32'h25;
      Instruction_code = instr;
      #1;
      checks++;
      if (Read_data1 !== 32'(i) || Read_data2 !== 32'(31 - i)) begin
        errors++;
        $display("[TB] FAIL reset_regs%0d got=%0d/%0d exp=%0d/%0d", i, Read_data1, Read_data2, i, 31 - i);
      end
    end
  endtask

  task automatic test_alu_codes();
    logic [5:0] functs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};
    logic [3:0] codes  [8] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7, 4'h8, 4'h9};
    tick();
    for (int k = 0; k < 8; k++) begin
      Instruction_code = {6'd0, 5'd1, 5'd2, 5'd0, 5'd3, functs[k]};
      #1;
      checks++;
      if (ALU_control !== codes[k] || RegWrite !== 1'b1 || Shamt !== 5'd3 ||
          Read_data1 !== 32'd1 || Read_data2 !== 32'd2) begin
        errors++;
        $display("[TB] FAIL alu_funct%0h got alu=%0h rw=%0b sh=%0d rd=%0d/%0d exp alu=%0h rw=1 sh=3 rd=1/2",
                 functs[k], ALU_control, RegWrite, Shamt, Read_data1, Read_data2, codes[k]);
      end
    end
  endtask

  task automatic test_add();
    tick();
    Instruction_code = 32'h00A6_2020; Write_data = 32'd11;
    #1;
    checks++;
    if (Read_data1 !== 32'd5 || Read_data2 !== 32'd6 || ALU_control !== 4'h2 || RegWrite !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_decode got rd=%0d/%0d alu=%0h rw=%0b exp 5/6 2 1", Read_data1, Read_data2, ALU_control, RegWrite);
    end
    tick();
    Instruction_code = 32'h0080_0025;
    #1;
    checks++;
    if (Read_data1 !== 32'd11) begin errors++; $display("[TB] FAIL add_writeback got=%0d exp=11", Read_data1); end
  endtask

  task automatic test_reg0();
    tick();
    Instruction_code = 32'h0000_0020; Write_data = 32'h0000_FFFF;
    #1;
    checks++;
    if (Read_data1 !== 32'd0) begin errors++; $display("[TB] FAIL reg0_before got=%0h exp=0", Read_data1); end
    tick();
    checks++;
    if (Read_data1 !== 32'd0) begin errors++; $display("[TB] FAIL reg0_after got=%0h exp=0", Read_data1); end
    checks++;
    if (Illegal !== 1'b0) begin errors++; $display("[TB] FAIL reg0_illegal got=%0b exp=0", Illegal); end
  endtask

  task automatic test_illegal();
    Instruction_code = 32'h0000_0021;
    #1;
    checks++;
    if (ALU_control !== 4'hF || RegWrite !== 1'b0) begin
      errors++; $display("[TB] FAIL bad_funct got alu=%0h rw=%0b exp F 0", ALU_control, RegWrite);
    end
    Instruction_code = 32'h8C01_0000; Write_data = 32'h1234;
    #1;
    checks++;
    if (ALU_control !== 4'hF || RegWrite !== 1'b0) begin
      errors++; $display("[TB] FAIL lw_decode got alu=%0h rw=%0b exp F 0", ALU_control, RegWrite);
    end
    tick();
    checks++;
    if (Illegal !== 1'b1) begin errors++; $display("[TB] FAIL lw_illegal got=%0b exp=1", Illegal); end
    checks++;
    if (Illegal_count !== ONE_ILLEGAL) begin errors++; $display("[TB] FAIL lw_count got=%0d exp=%0d", Illegal_count, ONE_ILLEGAL); end
    Instruction_code = 32'h0020_0025;
    #1;
    checks++;
    if (Read_data1 !== 32'd1) begin errors++; $display("[TB] FAIL lw_noreg got=%0h exp=1", Read_data1); end
  endtask

  task automatic test_back_to_back();
    tick();
    Instruction_code = 32'h0022_3820; Write_data = 32'd3;
    #1;
    checks++;
    if (Read_data1 !== 32'd1 || Read_data2 !== 32'd2) begin
      errors++; $display("[TB] FAIL b2b_first got=%0d/%0d exp=1/2", Read_data1, Read_data2);
    end
    tick();
    Instruction_code = 32'h00E0_4025; Write_data = 32'd3;
    #1;
    checks++;
    if (Read_data1 !== 32'd3 || ALU_control !== 4'h1) begin
      errors++; $display("[TB] FAIL b2b_second got rd1=%0d alu=%0h exp=3 1", Read_data1, ALU_control);
    end
    tick();
    Instruction_code = 32'h0100_0025;
    #1;
    checks++;
    if (Read_data1 !== 32'd3) begin errors++; $display("[TB] FAIL b2b_reg8 got=%0d exp=3", Read_data1); end
  endtask

  task automatic test_reset_override();
    tick();
    Instruction_code = 32'h0022_4820; Write_data = 32'hDEAD; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Instruction_code = 32'h0127_0025;
    #1;
    checks++;
    if (Read_data1 !== 32'd9 || Read_data2 !== 32'd7) begin
      errors++; $display("[TB] FAIL rst_override_regs got=%0h/%0h exp=9/7", Read_data1, Read_data2);
    end
    checks++;
    if (Illegal !== 1'b0 || Illegal_count !== 16'd0) begin
      errors++; $display("[TB] FAIL rst_override_flags got=%0b/%0d exp=0/0", Illegal, Illegal_count);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    Instruction_code = 32'h0000_0020;
    sat_reset = 1'b1;
    tick();
    sat_reset = 1'b0;
    checks++;
    if (sat_count !== 2'd0 || sat_illegal !== 1'b0) begin
      errors++; $display("[TB] FAIL sat_reset got=%0d/%0b exp=0/0", sat_count, sat_illegal);
    end
    sat_instr = 32'hFC00_0000;
    for (int n = 1; n <= 5; n++) begin
      tick();
      exp_cnt = CNT_ON ? ((n > 3) ? 2'd3 : 2'(n)) : 2'd0;
      checks++;
      if (sat_count !== exp_cnt || sat_illegal !== 1'b1) begin
        errors++; $display("[TB] FAIL sat_step%0d got=%0d/%0b exp=%0d/1", n, sat_count, sat_illegal, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_codes();
    test_add();
    test_reg0();
    test_illegal();
    test_back_to_back();
    test_reset_override();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
